// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC unit.
package npc_pkg;

    // Redirect buffering state of the fetch PC.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Which target feeds the PC this cycle.
    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JR  = 2'd3
    } sel_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop from an empty stack is ignored.
module npc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [CW-1:0]   cnt;

    // Write pointer points at the next free slot; count saturates at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
            if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
        end else if (pop && cnt != '0) begin
            wp  <= wp - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    // Top of stack is the most recent push, or zero when empty.
    always_comb begin
        valid = (cnt != '0);
        top   = valid ? mem[wp - 1'b1] : '0;
    end

endmodule

// File: rtl/npc_unit.sv
// Next-PC generation unit: fetch PC register, branch/jump/jr target
// selection, stall-time redirect buffering and jal link value.
// Optional return-address stack enabled by defining NPC_RAS_EN.
//
// state | meaning
// IDLE  | no redirect buffered
// PEND  | pend_tgt holds a redirect captured during a stall
module npc_unit
    import npc_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [XLEN-1:0] id_pc,
    input  logic            br_taken,
    input  logic [15:0]     imm16,
    input  logic            jmp,
    input  logic [25:0]     target26,
    input  logic            jal,
    input  logic            jr,
    input  logic [XLEN-1:0] rs_val,
    input  logic            ret,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_valid_o
);

    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC);

    state_t          state, state_nx;
    sel_t            sel;
    logic [XLEN-1:0] pc_nx;
    logic [XLEN-1:0] pend_tgt, pend_nx;
    logic            redirect_nx;
    logic [XLEN-1:0] seq_id;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;
    logic [XLEN-1:0] req_tgt;
    logic            req;

    // Request priority: jr over jmp over branch over sequential.
    always_comb begin
        if (jr)            sel = JR;
        else if (jmp)      sel = J;
        else if (br_taken) sel = BR;
        else               sel = SEQ;
    end

    // Candidate targets; all arithmetic wraps modulo 2^XLEN.
    always_comb begin
        seq_id  = id_pc + STEP;
        br_tgt  = seq_id + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
        j_tgt   = {seq_id[XLEN-1:28], target26, 2'b00};
        link_o  = seq_id + STEP;
        req     = (sel != SEQ);
        case (sel)
            JR:      req_tgt = rs_val;
            J:       req_tgt = j_tgt;
            BR:      req_tgt = br_tgt;
            default: req_tgt = '0;
        endcase
    end

    // State, PC, pending target and redirect flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_o       <= PC_INIT;
            pend_tgt   <= '0;
            redirect_o <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_o       <= pc_nx;
            pend_tgt   <= pend_nx;
            redirect_o <= redirect_nx;
        end
    end

    // Next-state and next-PC selection. The delay slot is already fetched,
    // so a target replaces pc_o+4 rather than being offset from it.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc_o;
        pend_nx     = pend_tgt;
        redirect_nx = 1'b0;
        case (state)
            IDLE: begin
                if (stall) begin
                    if (req) begin
                        pend_nx  = req_tgt;
                        state_nx = PEND;
                    end
                end else if (req) begin
                    pc_nx       = req_tgt;
                    redirect_nx = 1'b1;
                end else begin
                    pc_nx = pc_o + STEP;
                end
            end
            PEND: begin
                if (stall) begin
                    if (req) pend_nx = req_tgt;
                end else begin
                    pc_nx       = req ? req_tgt : pend_tgt;
                    redirect_nx = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef NPC_RAS_EN
    logic ras_push, ras_pop, ras_hold;

    // A request repeated across stall cycles is the same instruction, so the
    // stack is touched only on its first appearance.
    always_comb begin
        ras_push = (sel == J)  && jal && !ras_hold;
        ras_pop  = (sel == JR) && ret && !ras_hold;
    end

    // Remember that this stalled instruction already updated the stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ras_hold <= 1'b0;
        else        ras_hold <= stall && (ras_hold || ras_push || ras_pop);
    end

    npc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (link_o),
        .top   (ras_top_o),
        .valid (ras_valid_o)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_in;
    assign unused_ras_in = jal ^ ret;
    assign ras_top_o     = '0;
    assign ras_valid_o   = 1'b0;
`endif

endmodule

// File: tb/tb_npc_unit.sv
// Scoreboard bench for npc_unit: the driver pushes the expected post-edge
// state for every driven cycle; a monitor pops and compares after each edge.
module tb_npc_unit;

`ifdef NPC_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, br_taken, jmp, jal, jr, ret;
    logic [31:0] id_pc, rs_val;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] pc_o, link_o, ras_top_o;
    logic        redirect_o, ras_valid_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic        red;
        logic [31:0] top;
        logic        valid;
    } exp_t;

    exp_t q[$];

    npc_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0040_0000),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id_pc       (id_pc),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .jmp         (jmp),
        .target26    (target26),
        .jal         (jal),
        .jr          (jr),
        .rs_val      (rs_val),
        .ret         (ret),
        .pc_o        (pc_o),
        .link_o      (link_o),
        .redirect_o  (redirect_o),
        .ras_top_o   (ras_top_o),
        .ras_valid_o (ras_valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected item per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_o", pc_o, e.pc);
                chk("redirect_o", {31'b0, redirect_o}, {31'b0, e.red});
                chk("ras_top_o", ras_top_o, HAS_RAS ? e.top : 32'h0);
                chk("ras_valid_o", {31'b0, ras_valid_o}, {31'b0, HAS_RAS & e.valid});
            end
        end
    end

    task automatic clr();
        stall = 0; br_taken = 0; jmp = 0; jal = 0; jr = 0; ret = 0;
        id_pc = '0; rs_val = '0; imm16 = '0; target26 = '0;
    endtask

    // Called at a negedge with inputs already driven; consumes one cycle.
    task automatic go(input logic [31:0] pc, input logic red,
                      input logic [31:0] top, input logic valid);
        exp_t e;
        e.pc = pc; e.red = red; e.top = top; e.valid = valid;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d", q.size());
            q.delete();
        end
    endtask

    initial begin
        clr();
        repeat (2) @(negedge clk);
        chk("reset pc_o", pc_o, 32'h0040_0000);
        chk("reset redirect_o", {31'b0, redirect_o}, 32'h0);
        chk("reset ras_valid_o", {31'b0, ras_valid_o}, 32'h0);
        chk("reset ras_top_o", ras_top_o, 32'h0);
        rst_n = 1;

        // Sequential fetch.
        go(32'h0040_0004, 0, 0, 0);
        go(32'h0040_0008, 0, 0, 0);

        // Backward branch, then sequential resumes.
        id_pc = 32'h0040_0010; imm16 = 16'hFFFC; br_taken = 1;
        go(32'h0040_0004, 1, 0, 0);
        clr();
        go(32'h0040_0008, 0, 0, 0);

        // jr beats jmp and branch in the same cycle.
        id_pc = 32'h0040_0010; imm16 = 16'h0010; br_taken = 1;
        jmp = 1; target26 = 26'h0000100; jr = 1; rs_val = 32'h0040_1000;
        go(32'h0040_1000, 1, 0, 0);
        clr();
        go(32'h0040_1004, 0, 0, 0);

        // Branch captured under a 3-cycle stall, applied when stall drops.
        id_pc = 32'h0040_0010; imm16 = 16'h0010; br_taken = 1; stall = 1;
        go(32'h0040_1004, 0, 0, 0);
        go(32'h0040_1004, 0, 0, 0);
        go(32'h0040_1004, 0, 0, 0);
        clr();
        go(32'h0040_0054, 1, 0, 0);
        go(32'h0040_0058, 0, 0, 0);

        // A fresh request at stall release overrides the buffered one.
        id_pc = 32'h0040_0010; imm16 = 16'h0010; br_taken = 1; stall = 1;
        go(32'h0040_0058, 0, 0, 0);
        clr();
        jr = 1; rs_val = 32'h0040_2000;
        go(32'h0040_2000, 1, 0, 0);
        clr();

        // Jump keeps the upper nibble of id_pc+4; link is combinational.
        id_pc = 32'h1040_0000; target26 = 26'h0000100; jmp = 1;
        #1 chk("link_o jump", link_o, 32'h1040_0008);
        go(32'h1000_0400, 1, 0, 0);
        clr();

        // Branch target and link wrap modulo 2^32.
        id_pc = 32'hFFFF_FFFC; imm16 = 16'h0000; br_taken = 1;
        #1 chk("link_o wrap", link_o, 32'h0000_0004);
        go(32'h0000_0000, 1, 0, 0);
        clr();
        go(32'h0000_0004, 0, 0, 0);
        drain();

        // Reset mid-stall discards the buffered redirect.
        @(negedge clk);
        id_pc = 32'h0040_0010; imm16 = 16'h0010; br_taken = 1; stall = 1;
        go(32'h0000_0008, 0, 0, 0);
        drain();
        #1 rst_n = 0;
        #1 chk("async reset pc_o", pc_o, 32'h0040_0000);
        @(negedge clk);
        clr();
        rst_n = 1;
        go(32'h0040_0004, 0, 0, 0);

        // jal held across a stall pushes once; one ret empties the stack.
        id_pc = 32'h0040_0000; target26 = 26'h0000040; jmp = 1; jal = 1; stall = 1;
        go(32'h0040_0004, 0, 32'h0040_0008, 1);
        go(32'h0040_0004, 0, 32'h0040_0008, 1);
        go(32'h0040_0004, 0, 32'h0040_0008, 1);
        clr();
        go(32'h0000_0100, 1, 32'h0040_0008, 1);
        jr = 1; ret = 1; rs_val = 32'h0000_0200;
        go(32'h0000_0200, 1, 0, 0);
        clr();

        // Five pushes into a 4-deep stack, then five pops.
        for (int i = 1; i <= 5; i++) begin
            id_pc = 32'h1000 * i; jmp = 1; jal = 1;
            go(32'h0, 1, 32'h1000 * i + 32'h8, 1);
        end
        clr();
        jr = 1; ret = 1; rs_val = 32'h0000_0300;
        go(32'h300, 1, 32'h4008, 1);
        go(32'h300, 1, 32'h3008, 1);
        go(32'h300, 1, 32'h2008, 1);
        go(32'h300, 1, 32'h0, 0);
        go(32'h300, 1, 32'h0, 0);
        clr();

        // jr+ret with jmp+jal in the same cycle: only the pop happens.
        id_pc = 32'h0000_5000; jmp = 1; jal = 1;
        go(32'h0, 1, 32'h5008, 1);
        jr = 1; ret = 1; rs_val = 32'h0000_0400; br_taken = 1;
        go(32'h400, 1, 32'h0, 0);
        clr();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
